game_session_ctrl: RTL

//   Next-generation game controller: N-player score keeping, built-in countdown game timer,
//   pre-game READY countdown, pause/resume, winner/tie detection and session high score.

---
 rtl/game_session_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/game_session_ctrl.sv
// -----------------------------------------------------------------------------
// game_session_ctrl
//
// Multi-player game session controller. It keeps per-player scores, runs the
// game timer and the pre-game READY countdown, and handles pause/resume. It
// also detects the winner or a tie, and tracks the session high score.
//
// Ports
//   clkIn          system clock
//   reset          asynchronous, active-low reset
//   tick_1hz       1-cycle pulse per second (synchronous to clkIn)
//   start_game     1-cycle start / replay pulse
//   pause_toggle   1-cycle pause / resume pulse
//   player_scored  bit i = 1-cycle score pulse for player i
//   state          0 IDLE, 1 READY, 2 RUNNING, 3 PAUSED, 4 FINISH
//   game_active    1 only while RUNNING
//   time_left      READY: ready count; RUNNING/PAUSED: game seconds left
//   scores         player i at [i*SCORE_W +: SCORE_W], saturating
//   winner         players holding the maximum score (valid in FINISH)
//   tie            FINISH with more than one winner bit set
//   high_score     best single-player score since reset
//   new_high_score 1-cycle pulse when high_score is raised
//   game_over      1-cycle pulse on RUNNING -> FINISH
//
// The pulse inputs carry no handshake: each is a single-cycle event. It is
// sampled on the clock edge where it is high. Every output is a register, so
// it reflects its cause one cycle later.
// -----------------------------------------------------------------------------
module game_session_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int SCORE_W       = 6,
    parameter int GAME_SECONDS  = 30,
    parameter int READY_SECONDS = 3,
    parameter int TIMER_W       = 6
) (
    input  logic                           clkIn,
    input  logic                           reset,
    input  logic                           tick_1hz,
    input  logic                           start_game,
    input  logic                           pause_toggle,
    input  logic [NUM_PLAYERS-1:0]         player_scored,
    output logic [2:0]                     state,
    output logic                           game_active,
    output logic [TIMER_W-1:0]             time_left,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [NUM_PLAYERS-1:0]         winner,
    output logic                           tie,
    output logic [SCORE_W-1:0]             high_score,
    output logic                           new_high_score,
    output logic                           game_over
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READY   = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] GAME_T  = TIMER_W'(GAME_SECONDS);
    localparam logic [TIMER_W-1:0] READY_T = TIMER_W'(READY_SECONDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                           state_q, state_d;
    logic [TIMER_W-1:0]               time_q, time_d;
    logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
    logic [NUM_PLAYERS-1:0]           winner_q, winner_d;
    logic                             tie_q, tie_d;
    logic                             active_q, active_d;
    logic                             game_over_q, game_over_d;
    logic [SCORE_W-1:0]               high_q, high_d;
    logic                             new_high_q, new_high_d;

    logic [SCORE_W-1:0]               max_next;   // max over scores_d (winner)
    logic [SCORE_W-1:0]               max_cur;    // max over scores_q (high score)
    logic [NUM_PLAYERS-1:0]           lead_bits;

    assign state          = state_q;
    assign game_active    = active_q;
    assign time_left      = time_q;
    assign scores         = scores_q;
    assign winner         = winner_q;
    assign tie            = tie_q;
    assign high_score     = high_q;
    assign new_high_score = new_high_q;
    assign game_over      = game_over_q;

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        scores_d    = scores_q;
        game_over_d = 1'b0;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start_game) begin
                    scores_d = '0;
                    if (READY_SECONDS == 0) begin
                        state_d = S_RUNNING;
                        time_d  = GAME_T;
                    end else begin
                        state_d = S_READY;
                        time_d  = READY_T;
                    end
                end
            end
            S_READY: begin
                if (tick_1hz) begin
                    if (time_q == TIMER_W'(1)) begin
                        state_d = S_RUNNING;
                        time_d  = GAME_T;
                    end else begin
                        time_d = time_q - 1'b1;
                    end
                end
            end
            S_RUNNING: begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (player_scored[i] && scores_q[i*SCORE_W +: SCORE_W] != SCORE_MAX)
                        scores_d[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + 1'b1;
                end
                // The tick wins over a coinciding pause. An expiring tick
                // ends the game, and the pause is dropped.
                if (tick_1hz) begin
                    time_d = time_q - 1'b1;
                    if (time_q == TIMER_W'(1)) begin
                        state_d     = S_FINISH;
                        game_over_d = 1'b1;
                    end else if (pause_toggle) begin
                        state_d = S_PAUSED;
                    end
                end else if (pause_toggle) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (pause_toggle) state_d = S_RUNNING;
            end
            default: begin
                state_d  = S_IDLE;
                time_d   = '0;
                scores_d = '0;
            end
        endcase

        active_d = (state_d == S_RUNNING);
    end

    // Winner / tie from the scores that will be visible next cycle. This
    // makes winner/tie valid in the first FINISH cycle.
    always_comb begin
        max_next  = '0;
        lead_bits = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (scores_d[i*SCORE_W +: SCORE_W] > max_next) max_next = scores_d[i*SCORE_W +: SCORE_W];
        for (int i = 0; i < NUM_PLAYERS; i++)
            lead_bits[i] = (scores_d[i*SCORE_W +: SCORE_W] == max_next);
        winner_d = (state_d == S_FINISH) ? lead_bits : '0;
        tie_d    = ($countones(winner_d) > 1);
    end

    // High score is evaluated in the first FINISH cycle. That cycle is
    // marked by the registered game_over pulse, so the raise lands one cycle
    // after FINISH is entered.
    always_comb begin
        max_cur = '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (scores_q[i*SCORE_W +: SCORE_W] > max_cur) max_cur = scores_q[i*SCORE_W +: SCORE_W];
        high_d     = high_q;
        new_high_d = 1'b0;
        if (state_q == S_FINISH && game_over_q && max_cur > high_q) begin
            high_d     = max_cur;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            time_q      <= '0;
            scores_q    <= '0;
            winner_q    <= '0;
            tie_q       <= 1'b0;
            active_q    <= 1'b0;
            game_over_q <= 1'b0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            scores_q    <= scores_d;
            winner_q    <= winner_d;
            tie_q       <= tie_d;
            active_q    <= active_d;
            game_over_q <= game_over_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
        end
    end

endmodule
